// File: rtl/fractal_sync_node.sv
// fractal_sync_node: two-child barrier aggregation node of the fractal sync tree
module fractal_sync_node #(
  parameter int LVL_WIDTH      = 3,
  parameter int NODE_LVL       = 1,
  parameter bit IS_ROOT        = 1'b0,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             ch_req_i,
  input  logic [2*LVL_WIDTH-1:0] ch_lvl_i,
  output logic [1:0]             ch_ack_o,
  output logic                   parent_req_o,
  output logic [LVL_WIDTH-1:0]   parent_lvl_o,
  input  logic                   parent_ack_i,
  output logic                   error_o,
  output logic                   timeout_o,
  output logic [CNT_W-1:0]       sync_cnt_o
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, EVAL, FWD, ACK} state_t;
  state_t state_q, state_d;
  logic [1:0] pending_q, pending_d, cap, drop;
  logic [LVL_WIDTH-1:0] lvl0_q, lvl0_d, lvl1_q, lvl1_d;
  logic ok_q, ok_d, error_q, error_d, timeout_q, timeout_d, loc, fwd;
  logic [WW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // capture, protocol checks, pair classification and partner-wait timing
  always_comb begin
    cap = ch_req_i & ~pending_q & ~ch_ack_o;
    drop = pending_q & ~ch_req_i & {2{state_q != ACK}};
    loc = lvl0_q == lvl1_q && lvl0_q == LVL_WIDTH'(NODE_LVL);
    fwd = lvl0_q == lvl1_q && lvl0_q > LVL_WIDTH'(NODE_LVL) && !IS_ROOT;
    state_d = state_q;
    ok_d = ok_q;
    cnt_d = cnt_q;
    pending_d = pending_q | cap;
    lvl0_d = cap[0] ? ch_lvl_i[0 +: LVL_WIDTH] : lvl0_q;
    lvl1_d = cap[1] ? ch_lvl_i[LVL_WIDTH +: LVL_WIDTH] : lvl1_q;
    error_d = error_q | (|drop) | (parent_ack_i && state_q != FWD);
    wait_d = ^pending_q ? (wait_q == WW'(TIMEOUT_CYCLES) ? wait_q : wait_q + WW'(1)) : '0;
    timeout_d = timeout_q | (wait_d == WW'(TIMEOUT_CYCLES));
    case (state_q)
      IDLE: state_d = pending_q == 2'b11 ? EVAL : IDLE;
      EVAL: begin
        ok_d = loc | fwd;
        state_d = fwd ? FWD : ACK;
        error_d = error_d | !(loc | fwd);
      end
      FWD: state_d = parent_ack_i ? ACK : FWD;
      ACK: begin
        pending_d = '0;
        cnt_d = cnt_q + CNT_W'(ok_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pending_q <= '0;
      lvl0_q <= '0;
      lvl1_q <= '0;
      ok_q <= 1'b0;
      error_q <= 1'b0;
      timeout_q <= 1'b0;
      wait_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      lvl0_q <= lvl0_d;
      lvl1_q <= lvl1_d;
      ok_q <= ok_d;
      error_q <= error_d;
      timeout_q <= timeout_d;
      wait_q <= wait_d;
      cnt_q <= cnt_d;
    end
  end
  assign ch_ack_o = {2{state_q == ACK}};
  assign parent_req_o = state_q == FWD;
  assign parent_lvl_o = parent_req_o ? lvl0_q : '0;
  assign error_o = error_q;
  assign timeout_o = timeout_q;
  assign sync_cnt_o = cnt_q;
endmodule

// File: tb/tb_fractal_sync_node.sv
// tb_fractal_sync_node: vector table, corner sequences and randomized pairs against a transaction model
module tb_fractal_sync_node;
  localparam int LW = 3;
  logic clk_i = 1'b0, rst_i = 1'b1, parent_ack_i = 1'b0;
  logic [1:0] ch_req_i = '0;
  logic [2*LW-1:0] ch_lvl_i = '0;
  logic [1:0] ch_ack_o, sync_cnt_o;
  logic parent_req_o, error_o, timeout_o;
  logic [LW-1:0] parent_lvl_o;
  int total = 0, bad = 0;

  fractal_sync_node #(.LVL_WIDTH(LW), .NODE_LVL(1), .IS_ROOT(1'b0), .TIMEOUT_CYCLES(8), .CNT_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ch_req_i(ch_req_i), .ch_lvl_i(ch_lvl_i), .ch_ack_o(ch_ack_o),
    .parent_req_o(parent_req_o), .parent_lvl_o(parent_lvl_o), .parent_ack_i(parent_ack_i),
    .error_o(error_o), .timeout_o(timeout_o), .sync_cnt_o(sync_cnt_o));

  always #5 clk_i = ~clk_i;

  typedef struct {int rb, l0, l1, o0, o1, pd, ack_t, pr_t, prhi, cnt, err;} vec_t;
  vec_t tbl[10];

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    ch_req_i = '0;
    parent_ack_i = 1'b0;
    tick;
    rst_i = 1'b0;
  endtask

  // children raise at their offsets and hold until released; parent acks pd cycles after its request shows
  task automatic run_pair(input int l0, l1, o0, o1, pd, output int ack_t, ack_v, nack, pr_t, plvl, prhi);
    int t = 0;
    bit acked = 1'b0;
    ack_t = -1; ack_v = 0; nack = 0; pr_t = -1; plvl = 0; prhi = 0;
    ch_lvl_i = {LW'(l1), LW'(l0)};
    while (t < 100 && !(ack_t >= 0 && t >= ack_t + 2)) begin
      ch_req_i[0] = t >= o0 && !acked;
      ch_req_i[1] = t >= o1 && !acked;
      parent_ack_i = pr_t >= 0 && t == pr_t + pd;
      tick;
      t++;
      if (parent_req_o) begin
        prhi++;
        if (pr_t < 0) begin pr_t = t; plvl = int'(parent_lvl_o); end
      end
      if (ch_ack_o != 0) begin
        nack++;
        if (ack_t < 0) begin ack_t = t; ack_v = int'(ch_ack_o); end
        acked = 1'b1;
      end
    end
    ch_req_i = '0;
    parent_ack_i = 1'b0;
  endtask

  initial begin
    int ack_t, ack_v, nack, pr_t, plvl, prhi, m, ecnt, eto, eerr, seen;
    tbl = '{
      '{1, 1, 1, 0, 4, 0,  7, -1,  0, 1, 0},
      '{0, 2, 2, 0, 0, 13, 17, 3, 14, 2, 0},
      '{0, 3, 3, 2, 0, 0,  6,  5,  1, 3, 0},
      '{0, 1, 1, 1, 1, 0,  4, -1,  0, 0, 0},
      '{0, 1, 1, 0, 0, 0,  3, -1,  0, 1, 0},
      '{1, 1, 2, 0, 0, 0,  3, -1,  0, 0, 1},
      '{1, 0, 0, 0, 3, 0,  6, -1,  0, 0, 1},
      '{1, 2, 3, 1, 0, 0,  4, -1,  0, 0, 1},
      '{0, 1, 1, 0, 2, 0,  5, -1,  0, 1, 1},
      '{1, 7, 7, 0, 1, 2,  7,  4,  3, 1, 0}};
    tick;
    rst_i = 1'b0;
    chk("rst_ack", int'(ch_ack_o), 0);
    chk("rst_preq", int'(parent_req_o), 0);
    chk("rst_plvl", int'(parent_lvl_o), 0);
    chk("rst_err", int'(error_o), 0);
    chk("rst_to", int'(timeout_o), 0);
    chk("rst_cnt", int'(sync_cnt_o), 0);
    foreach (tbl[i]) begin
      if (tbl[i].rb != 0) do_reset;
      run_pair(tbl[i].l0, tbl[i].l1, tbl[i].o0, tbl[i].o1, tbl[i].pd, ack_t, ack_v, nack, pr_t, plvl, prhi);
      chk($sformatf("v%0d_ack_t", i), ack_t, tbl[i].ack_t);
      chk($sformatf("v%0d_ack_v", i), ack_v, 3);
      chk($sformatf("v%0d_nack", i), nack, 1);
      chk($sformatf("v%0d_pr_t", i), pr_t, tbl[i].pr_t);
      chk($sformatf("v%0d_prhi", i), prhi, tbl[i].prhi);
      chk($sformatf("v%0d_plvl", i), plvl, tbl[i].pr_t >= 0 ? tbl[i].l0 : 0);
      chk($sformatf("v%0d_cnt", i), int'(sync_cnt_o), tbl[i].cnt);
      chk($sformatf("v%0d_err", i), int'(error_o), tbl[i].err);
      chk($sformatf("v%0d_to", i), int'(timeout_o), 0);
    end
    do_reset;
    ch_lvl_i = {3'd1, 3'd1};
    ch_req_i = 2'b01;
    tick;
    tick;
    ch_req_i = 2'b00;
    tick;
    chk("drop_err", int'(error_o), 1);
    ch_req_i = 2'b10;
    tick;
    tick;
    tick;
    chk("drop_kept_ack", int'(ch_ack_o), 3);
    ch_req_i = 2'b00;
    tick;
    chk("drop_cnt", int'(sync_cnt_o), 1);
    do_reset;
    ch_lvl_i = {3'd1, 3'd1};
    ch_req_i = 2'b01;
    seen = 0;
    for (int i = 1; i <= 9; i++) begin
      tick;
      seen |= int'(ch_ack_o);
      if (i == 8) chk("to_before", int'(timeout_o), 0);
    end
    chk("to_set", int'(timeout_o), 1);
    chk("to_no_ack", seen, 0);
    ch_req_i = 2'b11;
    tick;
    tick;
    tick;
    chk("to_pair_ack", int'(ch_ack_o), 3);
    ch_req_i = 2'b00;
    tick;
    chk("to_sticky", int'(timeout_o), 1);
    chk("to_cnt", int'(sync_cnt_o), 1);
    chk("to_err", int'(error_o), 0);
    do_reset;
    ch_lvl_i = {3'd2, 3'd2};
    ch_req_i = 2'b11;
    for (int i = 0; i < 10 && !parent_req_o; i++) tick;
    chk("mf_preq_up", int'(parent_req_o), 1);
    rst_i = 1'b1;
    ch_req_i = 2'b00;
    tick;
    rst_i = 1'b0;
    chk("mf_preq", int'(parent_req_o), 0);
    chk("mf_plvl", int'(parent_lvl_o), 0);
    chk("mf_ack", int'(ch_ack_o), 0);
    chk("mf_cnt", int'(sync_cnt_o), 0);
    chk("mf_err", int'(error_o), 0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin tick; seen |= int'(ch_ack_o) | int'(parent_req_o); end
    chk("mf_quiet", seen, 0);
    parent_ack_i = 1'b1;
    tick;
    parent_ack_i = 1'b0;
    chk("mf_stray_ack_err", int'(error_o), 1);
    do_reset;
    ecnt = 0; eerr = 0; eto = 0;
    for (int n = 0; n < 40; n++) begin
      int l0, l1, o0, o1, pd;
      bit good, fw;
      l0 = int'($urandom_range(0, 3));
      l1 = $urandom_range(0, 2) != 0 ? l0 : int'($urandom_range(0, 3));
      o0 = int'($urandom_range(0, 10));
      o1 = int'($urandom_range(0, 10));
      pd = int'($urandom_range(0, 4));
      m = o0 > o1 ? o0 : o1;
      good = l0 == l1 && l0 >= 1;
      fw = good && l0 > 1;
      ecnt = (ecnt + int'(good)) % 4;
      eerr |= int'(!good);
      eto |= int'((o0 > o1 ? o0 - o1 : o1 - o0) >= 8);
      run_pair(l0, l1, o0, o1, pd, ack_t, ack_v, nack, pr_t, plvl, prhi);
      chk($sformatf("r%0d_ack_t", n), ack_t, fw ? m + 4 + pd : m + 3);
      chk($sformatf("r%0d_nack", n), nack, 1);
      chk($sformatf("r%0d_pr_t", n), pr_t, fw ? m + 3 : -1);
      chk($sformatf("r%0d_prhi", n), prhi, fw ? pd + 1 : 0);
      chk($sformatf("r%0d_plvl", n), plvl, fw ? l0 : 0);
      chk($sformatf("r%0d_cnt", n), int'(sync_cnt_o), ecnt);
      chk($sformatf("r%0d_err", n), int'(error_o), eerr);
      chk($sformatf("r%0d_to", n), int'(timeout_o), eto);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
